// File: rtl/display_scan_mux.sv
// ============================================================================
// display_scan_mux
// ----------------------------------------------------------------------------
// Time-multiplexes CH_COUNT pairs of hex-digit words onto one display.
// In MANUAL mode the displayed channel follows sel_in every cycle; in AUTO
// mode the channel advances after DWELL_CYCLES cycles, or at once on a
// step_in pulse. hold_in freezes everything. Selecting a channel that does
// not exist (MANUAL only) shows the 0x0DAB pattern with no selector bit set.
//
// Optional feature (compile-time macro DISPLAY_SCAN_MUX_BLANK_EN):
//   every change of the displayed channel raises blank_out and forces
//   selector_out to zero for BLANK_CYCLES cycles, so the previous digit
//   does not ghost onto the newly enabled display. Without the macro
//   blank_out is tied to 0 and no blank counter exists.
//
// Parameters
//   DATA_WIDTH    word width per side, multiple of 4, 4..32
//   CH_COUNT      number of channels, 2..2**SEL_W-1
//   SEL_W         width of the channel select / index
//   DWELL_CYCLES  AUTO dwell per channel, >= 2
//   BLANK_CYCLES  blank length after a channel change, 1..DWELL_CYCLES-1
//
// Ports
//   clock         single clock, rising edge
//   reset         asynchronous, active-high
//   mode_in       0 = MANUAL, 1 = AUTO
//   sel_in        manual channel select
//   step_in       single-cycle advance pulse (AUTO only)
//   hold_in       freeze all state and outputs while high
//   l_data_in     left words, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   r_data_in     right words, same packing
//   l_digits_out  registered left word of the displayed channel
//   r_digits_out  registered right word of the displayed channel
//   selector_out  registered one-hot, channel k drives bit CH_COUNT-1-k
//   cur_ch_out    registered index of the displayed channel
//   blank_out     registered ghost-blank indicator
// ============================================================================
module display_scan_mux #(
    parameter int DATA_WIDTH   = 16,
    parameter int CH_COUNT     = 8,
    parameter int SEL_W        = 4,
    parameter int DWELL_CYCLES = 50000000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           mode_in,
    input  logic [SEL_W-1:0]               sel_in,
    input  logic                           step_in,
    input  logic                           hold_in,
    input  logic [CH_COUNT*DATA_WIDTH-1:0] l_data_in,
    input  logic [CH_COUNT*DATA_WIDTH-1:0] r_data_in,
    output logic [DATA_WIDTH-1:0]          l_digits_out,
    output logic [DATA_WIDTH-1:0]          r_digits_out,
    output logic [CH_COUNT-1:0]            selector_out,
    output logic [SEL_W-1:0]               cur_ch_out,
    output logic                           blank_out
);

    // ------------------------------------------------------------------------
    // Parameter sanity
    // ------------------------------------------------------------------------
    if (DATA_WIDTH < 4 || DATA_WIDTH > 32 || (DATA_WIDTH % 4) != 0) begin : g_bad_data_width
        $error("display_scan_mux: DATA_WIDTH must be a multiple of 4 in 4..32");
    end
    if (CH_COUNT < 2 || CH_COUNT > (2 ** SEL_W) - 1) begin : g_bad_ch_count
        $error("display_scan_mux: CH_COUNT must be in 2..2**SEL_W-1");
    end
    if (DWELL_CYCLES < 2) begin : g_bad_dwell
        $error("display_scan_mux: DWELL_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES >= DWELL_CYCLES) begin : g_bad_blank
        $error("display_scan_mux: BLANK_CYCLES must be in 1..DWELL_CYCLES-1");
    end

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int               DW           = $clog2(DWELL_CYCLES);
    localparam logic [DW-1:0]    DWELL_LAST   = DW'(DWELL_CYCLES - 1);
    localparam logic [SEL_W-1:0] CH_LAST      = SEL_W'(CH_COUNT - 1);
    // Shown on both sides when the selected channel does not exist; the
    // low DATA_WIDTH bits give zero-extension or truncation as needed.
    localparam logic [31:0]      INVALID_WORD = 32'h0000_0DAB;

    typedef enum logic {
        MANUAL = 1'b0,
        AUTO   = 1'b1
    } mode_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    mode_t            mode;        // mode seen at the last update, for edge detect
    mode_t            mode_next;
    logic [SEL_W-1:0] ch;
    logic [SEL_W-1:0] ch_next;
    logic [DW-1:0]    dwell;
    logic [DW-1:0]    dwell_next;

    logic                  sel_valid;
    logic                  advance;
    logic [DATA_WIDTH-1:0] l_word;
    logic [DATA_WIDTH-1:0] r_word;
    logic [CH_COUNT-1:0]   onehot;

    assign sel_valid = (sel_in <= CH_LAST);
    // A step landing on the terminal count is still a single advance.
    assign advance   = step_in || (dwell == DWELL_LAST);

    // ------------------------------------------------------------------------
    // Next-state logic for mode, channel and dwell counter
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves one unassigned would infer a latch.
        mode_next  = mode_t'(mode_in);
        ch_next    = ch;
        dwell_next = dwell;

        if (mode_in == AUTO) begin
            if (mode == MANUAL) begin
                // Entering AUTO: start from the manual pick when it exists.
                ch_next    = sel_valid ? sel_in : '0;
                dwell_next = '0;
            end else if (advance) begin
                ch_next    = (ch >= CH_LAST) ? '0 : ch + 1'b1;
                dwell_next = '0;
            end else begin
                dwell_next = dwell + 1'b1;
            end
        end else begin
            // MANUAL follows sel_in directly; step_in has no effect here.
            ch_next    = sel_in;
            dwell_next = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            mode  <= MANUAL;
            ch    <= '0;
            dwell <= '0;
        end else if (!hold_in) begin
            mode  <= mode_next;
            ch    <= ch_next;
            dwell <= dwell_next;
        end
    end

    // ch is itself the registered display index.
    assign cur_ch_out = ch;

    // ------------------------------------------------------------------------
    // Word and selector lookup for the channel about to be displayed.
    // A compare loop keeps every part-select in range for invalid indices.
    // ------------------------------------------------------------------------
    always_comb begin
        l_word = INVALID_WORD[DATA_WIDTH-1:0];
        r_word = INVALID_WORD[DATA_WIDTH-1:0];
        onehot = '0;
        for (int k = 0; k < CH_COUNT; k++) begin
            if (ch_next == SEL_W'(k)) begin
                l_word                 = l_data_in[k*DATA_WIDTH +: DATA_WIDTH];
                r_word                 = r_data_in[k*DATA_WIDTH +: DATA_WIDTH];
                onehot[CH_COUNT-1-k]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            l_digits_out <= '0;
            r_digits_out <= '0;
        end else if (!hold_in) begin
            l_digits_out <= l_word;
            r_digits_out <= r_word;
        end
    end

    // ------------------------------------------------------------------------
    // Selector and ghost blanking
    // ------------------------------------------------------------------------
`ifdef DISPLAY_SCAN_MUX_BLANK_EN
    // blank_left counts the blank cycles still owed after the current one.
    localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

    logic [BW-1:0] blank_left;
    logic          ch_change;

    assign ch_change = (ch_next != ch);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blank_left   <= '0;
            blank_out    <= 1'b0;
            selector_out <= '0;
        end else if (!hold_in) begin
            if (ch_change) begin
                // A new index (re)starts the blank even if one is running.
                blank_left   <= BW'(BLANK_CYCLES - 1);
                blank_out    <= 1'b1;
                selector_out <= '0;
            end else if (blank_left != '0) begin
                blank_left   <= blank_left - 1'b1;
                blank_out    <= 1'b1;
                selector_out <= '0;
            end else begin
                blank_out    <= 1'b0;
                selector_out <= onehot;
            end
        end
    end
`else
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            selector_out <= '0;
        end else if (!hold_in) begin
            selector_out <= onehot;
        end
    end

    assign blank_out = 1'b0;
`endif

endmodule

// File: tb/tb_display_scan_mux.sv
// ============================================================================
// tb_display_scan_mux
// ----------------------------------------------------------------------------
// Self-checking bench for display_scan_mux with DWELL_CYCLES=4 and
// BLANK_CYCLES=2. A cycle-level reference model computes the expected
// outputs from the display rules with integer arithmetic; directed
// scenarios additionally compare against literal expected sequences.
// Build with DISPLAY_SCAN_MUX_BLANK_EN defined to cover the blank feature.
// ============================================================================
module tb_display_scan_mux;

    localparam int DW    = 16;
    localparam int CH    = 8;
    localparam int SW    = 4;
    localparam int DWELL = 4;
    localparam int BLANK = 2;

`ifdef DISPLAY_SCAN_MUX_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    logic              clock;
    logic              reset;
    logic              mode;
    logic [SW-1:0]     sel;
    logic              step;
    logic              hold;
    logic [CH*DW-1:0]  l_data;
    logic [CH*DW-1:0]  r_data;
    logic [DW-1:0]     l_digits;
    logic [DW-1:0]     r_digits;
    logic [CH-1:0]     selector;
    logic [SW-1:0]     cur_ch;
    logic              blank;

    logic [DW-1:0]     lw [CH];
    logic [DW-1:0]     rw [CH];

    int checks = 0;
    int errors = 0;

    display_scan_mux #(
        .DATA_WIDTH  (DW),
        .CH_COUNT    (CH),
        .SEL_W       (SW),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode_in     (mode),
        .sel_in      (sel),
        .step_in     (step),
        .hold_in     (hold),
        .l_data_in   (l_data),
        .r_data_in   (r_data),
        .l_digits_out(l_digits),
        .r_digits_out(r_digits),
        .selector_out(selector),
        .cur_ch_out  (cur_ch),
        .blank_out   (blank)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb begin
        l_data = '0;
        r_data = '0;
        for (int k = 0; k < CH; k++) begin
            l_data[k*DW +: DW] = lw[k];
            r_data[k*DW +: DW] = rw[k];
        end
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int            m_ch;
    int            m_dwell;       // cycles already spent on m_ch in AUTO
    int            m_blank_left;  // blank cycles still to show
    bit            m_auto;
    logic [DW-1:0] exp_l, exp_r;
    logic [CH-1:0] exp_sel;
    logic [SW-1:0] exp_cur;
    logic          exp_blank;

    wire  [44:0] got  = {l_digits, r_digits, selector, cur_ch, blank};
    wire  [44:0] want = {exp_l, exp_r, exp_sel, exp_cur, exp_blank};

    function automatic logic [CH-1:0] onehot_of(int c);
        return (c < CH) ? CH'(1 << (CH - 1 - c)) : '0;
    endfunction

    task automatic model_reset();
        m_ch = 0; m_dwell = 0; m_blank_left = 0; m_auto = 1'b0;
        exp_l = '0; exp_r = '0; exp_sel = '0; exp_cur = '0; exp_blank = 1'b0;
    endtask

    task automatic model_step();
        if (reset) begin
            model_reset();
        end else if (!hold) begin
            if (mode) begin
                if (!m_auto) begin
                    m_ch    = (int'(sel) < CH) ? int'(sel) : 0;
                    m_dwell = 0;
                end else if (step || m_dwell == DWELL - 1) begin
                    m_ch    = (m_ch + 1) % CH;
                    m_dwell = 0;
                end else begin
                    m_dwell = m_dwell + 1;
                end
            end else begin
                m_ch    = int'(sel);
                m_dwell = 0;
            end
            m_auto = mode;

            if (m_ch < CH) begin
                exp_l = lw[m_ch];
                exp_r = rw[m_ch];
            end else begin
                exp_l = 16'h0DAB;
                exp_r = 16'h0DAB;
            end
`ifdef DISPLAY_SCAN_MUX_BLANK_EN
            if (m_ch != int'(exp_cur)) m_blank_left = BLANK;
            if (m_blank_left > 0) begin
                exp_blank    = 1'b1;
                exp_sel      = '0;
                m_blank_left = m_blank_left - 1;
            end else begin
                exp_blank = 1'b0;
                exp_sel   = onehot_of(m_ch);
            end
`else
            exp_blank = 1'b0;
            exp_sel   = onehot_of(m_ch);
`endif
            exp_cur = SW'(m_ch);
        end
    endtask

    // Inputs change on the falling edge; outputs are read on the next one.
    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic randomize_data();
        for (int k = 0; k < CH; k++) begin
            lw[k] = DW'($urandom);
            rw[k] = DW'($urandom);
        end
    endtask

    // ------------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; mode = 1'b1; sel = 4'd5; step = 1'b0; hold = 1'b0;
        randomize_data();
        model_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (got !== 45'd0) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got=%h want=0", i, got);
            end
        end
        reset = 1'b0; mode = 1'b0; sel = 4'd3;
        tick();
        checks++;
        if (got !== want || cur_ch !== 4'd3) begin
            errors++;
            $display("FAIL reset_first_edge got=%h want=%h", got, want);
        end
    endtask

    task automatic test_manual();
        mode = 1'b0;
        lw[2] = 16'h1234; rw[2] = 16'hABCD; sel = 4'd2;
        tick();
        checks++;
        if (l_digits !== 16'h1234 || r_digits !== 16'hABCD || cur_ch !== 4'd2 || got !== want) begin
            errors++;
            $display("FAIL manual_ch2 got=%h want=%h", got, want);
        end
        tick(); tick();
        checks++;
        if (selector !== 8'b0010_0000 || got !== want) begin
            errors++;
            $display("FAIL manual_ch2_sel got=%b want=00100000", selector);
        end
        sel = 4'd9;
        tick();
        checks++;
        if (l_digits !== 16'h0DAB || r_digits !== 16'h0DAB || selector !== 8'h00 || cur_ch !== 4'd9) begin
            errors++;
            $display("FAIL manual_invalid got=%h want l=0dab r=0dab sel=00 ch=9", got);
        end
        for (int i = 0; i < 24; i++) begin
            sel  = SW'($urandom_range(0, 15));
            step = ($urandom_range(0, 3) == 0);
            randomize_data();
            tick();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL manual_rand cyc %0d got=%h want=%h", i, got, want);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_auto_scan();
        int seq[9] = '{6, 6, 6, 6, 7, 7, 7, 7, 0};
        logic [CH-1:0] sel_last;
        mode = 1'b0; sel = 4'd6;
        repeat (3) tick();
        mode = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (int'(cur_ch) != seq[i] || got !== want) begin
                errors++;
                $display("FAIL auto_scan cyc %0d got ch=%0d want ch=%0d (got=%h want=%h)", i, cur_ch, seq[i], got, want);
            end
            if (i == 3 || i == 7) begin
                checks++;
                if (selector !== onehot_of(seq[i])) begin
                    errors++;
                    $display("FAIL auto_scan_sel cyc %0d got=%b want=%b", i, selector, onehot_of(seq[i]));
                end
            end
        end
        sel_last = BLANK_ON ? 8'h00 : 8'b1000_0000;
        checks++;
        if (selector !== sel_last) begin
            errors++;
            $display("FAIL auto_wrap_sel got=%b want=%b", selector, sel_last);
        end
    endtask

    task automatic test_step();
        int seq_a[5] = '{1, 1, 1, 1, 2};
        int seq_b[8] = '{2, 2, 2, 3, 3, 3, 3, 4};
        mode = 1'b0; sel = 4'd0; step = 1'b0;
        repeat (3) tick();
        mode = 1'b1;
        tick();   // AUTO starts on channel 0, count 0
        tick();   // count 1
        for (int i = 0; i < 5; i++) begin
            step = (i == 0);
            tick();
            checks++;
            if (int'(cur_ch) != seq_a[i] || got !== want) begin
                errors++;
                $display("FAIL step_mid cyc %0d got ch=%0d want ch=%0d", i, cur_ch, seq_a[i]);
            end
        end
        for (int i = 0; i < 8; i++) begin
            step = (i == 3);   // lands on the terminal count
            tick();
            checks++;
            if (int'(cur_ch) != seq_b[i] || got !== want) begin
                errors++;
                $display("FAIL step_terminal cyc %0d got ch=%0d want ch=%0d", i, cur_ch, seq_b[i]);
            end
        end
        step = 1'b0;
    endtask

    task automatic test_hold();
        logic [44:0] frozen;
        tick(); tick();   // channel 4, count 2
        frozen = want;
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            randomize_data();
            step = $urandom_range(0, 1);
            sel  = SW'($urandom_range(0, 15));
            tick();
            checks++;
            if (got !== frozen) begin
                errors++;
                $display("FAIL hold_frozen cyc %0d got=%h want=%h", i, got, frozen);
            end
        end
        hold = 1'b0; step = 1'b0;
        tick();
        checks++;
        if (cur_ch !== 4'd4 || got !== want) begin
            errors++;
            $display("FAIL hold_resume1 got ch=%0d want ch=4", cur_ch);
        end
        tick();
        checks++;
        if (cur_ch !== 4'd5 || got !== want) begin
            errors++;
            $display("FAIL hold_resume2 got ch=%0d want ch=5", cur_ch);
        end
    endtask

    task automatic test_blank();
        logic [CH-1:0] s_exp [3];
        logic          b_exp [3];
        mode = 1'b0; sel = 4'd0;
        repeat (3) tick();
        s_exp[0] = BLANK_ON ? 8'h00 : 8'b0100_0000;
        s_exp[1] = s_exp[0];
        s_exp[2] = 8'b0100_0000;
        b_exp[0] = BLANK_ON;
        b_exp[1] = BLANK_ON;
        b_exp[2] = 1'b0;
        sel = 4'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (selector !== s_exp[i] || blank !== b_exp[i] || got !== want) begin
                errors++;
                $display("FAIL blank_seq cyc %0d got sel=%b blk=%b want sel=%b blk=%b", i, selector, blank, s_exp[i], b_exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seq[5] = '{5, 5, 5, 5, 6};
        mode = 1'b1; sel = 4'd5;
        tick(); tick();   // mid-dwell, and mid-blank when blanking is built in
        #2 reset = 1'b1;
        #1;
        model_reset();
        checks++;
        if (got !== 45'd0) begin
            errors++;
            $display("FAIL reset_async got=%h want=0", got);
        end
        tick();
        checks++;
        if (got !== 45'd0 || got !== want) begin
            errors++;
            $display("FAIL reset_held got=%h want=0", got);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (int'(cur_ch) != seq[i] || got !== want) begin
                errors++;
                $display("FAIL reset_restart cyc %0d got ch=%0d want ch=%0d (got=%h want=%h)", i, cur_ch, seq[i], got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            hold = ($urandom_range(0, 7) == 0);
            step = ($urandom_range(0, 3) == 0);
            sel  = SW'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) randomize_data();
            tick();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got=%h want=%h", i, got, want);
            end
        end
        hold = 1'b0; step = 1'b0;
    endtask

    initial begin
        test_reset();
        test_manual();
        test_auto_scan();
        test_step();
        test_hold();
        test_blank();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, digit-pair word width in bits; multiple of 4, range 4..32.
REQ-002 SHALL have parameter CH_COUNT, default 8, number of display channels; range 2..2**SEL_W-1.
REQ-003 SHALL have parameter SEL_W, default 4, width of the channel select.
REQ-004 SHALL have parameter DWELL_CYCLES, default 50000000, auto-scan dwell per channel; range 2 or more.
REQ-005 SHALL have parameter BLANK_CYCLES, default 1000, ghost-blank length; range 1..DWELL_CYCLES-1.
REQ-006 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-008 SHALL have port mode_in, input, 1, 0 = MANUAL, 1 = AUTO.
REQ-009 SHALL have port sel_in, input, SEL_W, manual channel select.
REQ-010 SHALL have port step_in, input, 1, synchronous single-cycle advance pulse; used in AUTO only.
REQ-011 SHALL have port hold_in, input, 1, freezes all state while high.
REQ-012 SHALL have port l_data_in, input, CH_COUNT*DATA_WIDTH, left word of channel k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-013 SHALL have port r_data_in, input, CH_COUNT*DATA_WIDTH, right word, same packing as l_data_in.
REQ-014 SHALL have port l_digits_out, output, DATA_WIDTH, registered left hex nibbles; nibble 0 = least significant digit.
REQ-015 SHALL have port r_digits_out, output, DATA_WIDTH, registered right hex nibbles.
REQ-016 SHALL have port selector_out, output, CH_COUNT, registered one-hot; channel k drives bit CH_COUNT-1-k.
REQ-017 SHALL have port cur_ch_out, output, SEL_W, registered index of the channel currently displayed.
REQ-018 SHALL have port blank_out, output, 1, registered ghost-blank indicator.

Function
REQ-019 SHALL keep an internal channel index ch; outputs SHALL reflect ch and input data one cycle after they are sampled.
REQ-020 In MANUAL, ch SHALL be loaded with sel_in every cycle.
REQ-021 In AUTO, a dwell counter SHALL count 0..DWELL_CYCLES-1; at terminal count ch SHALL advance by 1 and the counter SHALL clear.
REQ-022 ch SHALL wrap from CH_COUNT-1 to 0.
REQ-023 In AUTO, step_in=1 SHALL advance ch by 1 and clear the dwell counter.
REQ-024 step_in coinciding with dwell terminal count SHALL advance ch by exactly one.
REQ-025 In MANUAL, step_in SHALL be ignored.
REQ-026 On a MANUAL->AUTO transition, scanning SHALL start from sel_in if sel_in < CH_COUNT, otherwise from 0, with the dwell counter cleared.
REQ-027 On an AUTO->MANUAL transition, ch SHALL take sel_in on the next cycle.
REQ-028 hold_in=1 SHALL freeze ch, the dwell counter, the blank counter and all outputs; step_in during hold SHALL be dropped.
REQ-029 For valid ch (< CH_COUNT): l_digits_out/r_digits_out SHALL equal channel ch words, selector_out one-hot per REQ-016, cur_ch_out = ch.
REQ-030 For invalid ch (MANUAL only): digits SHALL be pattern 0x0DAB zero-extended or truncated to DATA_WIDTH, selector_out all 0, cur_ch_out = ch.
REQ-031 Input data SHALL be re-sampled every non-hold cycle, so live data changes track with 1-cycle latency.

Reset
REQ-032 While reset=1: ch, dwell counter and blank counter SHALL be 0.
REQ-033 While reset=1: l_digits_out, r_digits_out, selector_out, cur_ch_out and blank_out SHALL be 0, asynchronously.
REQ-034 Reset asserted mid-dwell or mid-blank SHALL abort the count with no residual state.
REQ-035 After reset deasserts, the first rising edge SHALL load state per the current mode_in.

Configuration
REQ-036 Macro DISPLAY_SCAN_MUX_BLANK_EN defined: on every change of cur_ch_out, blank_out SHALL be 1 and selector_out forced to 0 for BLANK_CYCLES cycles, starting the cycle the new index appears; digits SHALL still update.
REQ-037 A further channel change during blanking SHALL restart the blank count.
REQ-038 Macro DISPLAY_SCAN_MUX_BLANK_EN not defined: blank_out SHALL be constant 0, there SHALL be no blank counter, and selector_out SHALL follow REQ-029/030 only.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=2, defaults otherwise)
REQ-039 MANUAL, sel_in=2, l word 2 = 0x1234, r word 2 = 0xABCD -> next cycle l_digits_out=0x1234, r_digits_out=0xABCD, selector_out=0010_0000.
REQ-040 MANUAL, sel_in=9 -> l/r_digits_out=0x0DAB, selector_out=0x00, cur_ch_out=9.
REQ-041 AUTO from sel_in=6 -> cur_ch_out 6,6,6,6,7,7,7,7,0; selector_out 0000_0010 -> 0000_0001 -> 1000_0000.
REQ-042 AUTO, step_in pulsed at dwell count 1 -> immediate advance, next advance 4 cycles later; step on terminal count -> advance by 1 only.
REQ-043 hold_in high 10 cycles in AUTO with data changing -> all outputs constant; resumes the remaining dwell after release.
REQ-044 With DISPLAY_SCAN_MUX_BLANK_EN, channel 0->1 -> blank_out=1, selector_out=0x00 for 2 cycles, then 0100_0000; reset pulse mid-blank -> all outputs 0 immediately.
